dr_tx_sched: RTL and testbench

Sequencing and arbitration controller for the dual-rail transmit encoder. It shares one encoder between `NREQ` synchronous requesters using round-robin arbitration. It runs the four-phase return-to-zero handshake: data, then ack high, then spacer, then ack low. It sits between the synchronous core and the encoder's `in`/`in_rdy` inputs, and consumes the receiver's asynchronous completion ack.

---
 rtl/dr_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_dr_tx_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_tx_sched.sv
// dr_tx_sched: sequencer and round-robin arbiter for the dual-rail transmit
// encoder. NREQ synchronous requesters share one encoder. Each transfer runs
// the four-phase return-to-zero handshake: data with enc_rdy high, wait for
// ack high, spacer with enc_rdy low, wait for ack low.
//
// Ports
//   clk, rst_n   sole clock; asynchronous active-low reset
//   req_valid    per-requester request
//   req_data     payloads; requester i owns bits [i*N +: N]
//   req_ready    one-hot, one-cycle accept pulse (combinational, IDLE only)
//   enc_data     payload to the encoder, held stable while enc_rdy = 1
//   enc_rdy      1 = data phase, 0 = spacer
//   ack_async    receiver completion ack, asynchronous to clk
//   grant_id     index of the requester currently being sent
//   busy         high whenever the sequencer is not IDLE
//   timeout_err  sticky ack-timeout flag
//   clear_err    synchronous clear of timeout_err (a set in the same cycle wins)
module dr_tx_sched #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [N-1:0]              enc_data,
  output logic                      enc_rdy,
  input  logic                      ack_async,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clear_err
);

  localparam int GW = $clog2(NREQ);
  localparam logic [7:0] TO_FULL = 8'(TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_SPACER} state_t;

  state_t          state;
  logic            ack_meta;
  logic            ack_s;
  logic [GW-1:0]   ptr;
  logic [7:0]      cnt;

  logic [GW-1:0]   lo_win;
  logic [GW-1:0]   hi_win;
  logic            hi_hit;
  logic [GW-1:0]   win;
  logic [N-1:0]    win_data;
  logic            any_req;

  assign any_req = |req_valid;

  // Round-robin pick: the lowest valid index at or above the pointer wins,
  // otherwise the lowest valid index overall (the wrap-around case).
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    lo_win = '0;
    hi_win = '0;
    hi_hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_win = GW'(i);
        if (GW'(i) >= ptr) begin
          hi_win = GW'(i);
          hi_hit = 1'b1;
        end
      end
    end
    win = hi_hit ? hi_win : lo_win;
  end

  assign win_data = req_data[int'(win)*N +: N];

  // Accept pulse is combinational so the requester sees it in the same cycle
  // the grant edge is prepared; gating with rst_n keeps it low during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && any_req) req_ready[win] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: all state here is control/datapath registers (no memories), so every
  // flop is asynchronously reset; a reset mid-transfer drops enc_rdy at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ack_meta    <= 1'b0;
      ack_s       <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      enc_data    <= '0;
      enc_rdy     <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Two-flop synchronizer: the only place ack_async is sampled.
      ack_meta <= ack_async;
      ack_s    <= ack_meta;

      // Clear first; any set below is a later assignment and therefore wins.
      if (clear_err) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (any_req) begin
            state    <= S_DATA;
            enc_data <= win_data;
            grant_id <= win;
            ptr      <= (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
            enc_rdy  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_DATA: begin
          if (ack_s) begin
            state   <= S_SPACER;
            enc_rdy <= 1'b0;
            cnt     <= '0;
          end else if (cnt == TO_LAST) begin
            // TIMEOUT data cycles without an ack: drop the word, go to spacer.
            state       <= S_SPACER;
            enc_rdy     <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_SPACER: begin
          if (!ack_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            // Ack stuck high: flag once, park the counter, keep waiting.
            cnt         <= TO_FULL;
            timeout_err <= 1'b1;
          end else if (cnt != TO_FULL) begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state   <= S_IDLE;
          enc_rdy <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dr_tx_sched.sv
// Self-checking bench for dr_tx_sched. Requesters hold per-index payload
// FIFOs; a grant observer predicts the winner from a modular round-robin
// model and pushes the expected transfer into a scoreboard; a separate
// monitor pops it when the encoder data phase starts and compares.
module tb_dr_tx_sched;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int TO   = 10;
  localparam int GW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*N-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic [N-1:0]         enc_data;
  logic                 enc_rdy;
  logic                 ack_async;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 timeout_err;
  logic                 clear_err = 1'b0;

  always #5 clk = ~clk;

  dr_tx_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .enc_data    (enc_data),
    .enc_rdy     (enc_rdy),
    .ack_async   (ack_async),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requesters ----------------
  logic [N-1:0] pbuf [NREQ][16];
  int head [NREQ] = '{default: 0};
  int tail [NREQ] = '{default: 0};
  logic force_all = 1'b1;

  task automatic push(input int i, input logic [N-1:0] d);
    pbuf[i][tail[i] % 16] = d;
    tail[i]++;
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = force_all || (head[i] != tail[i]);
        req_data[i*N +: N] = pbuf[i][head[i] % 16];
      end
    end
  end

  // ---------------- grant observer + reference model ----------------
  typedef struct {
    int          id;
    logic [N-1:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   mptr = 0;

  always @(negedge clk) begin : grant_obs
    int w;
    if (!rst_n) begin
      mptr = 0;
    end else if (req_ready != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      end
      check("ready_only_when_idle", busy, 0);
      if (w < 0) begin
        check("grant_without_request", req_ready, 0);
      end else begin
        check("req_ready_onehot", req_ready, 32'(1) << w);
        exp_q.push_back('{w, pbuf[w][head[w] % 16], cyc});
        gnt_log.push_back(w);
        head[w]++;
        mptr = (w + 1) % NREQ;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_rdy = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
      exp_q.delete();
    end else begin
      if (enc_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_transfer: enc_rdy rose with data 0x%0h, no grant pending", enc_data);
        end else begin
          cur = exp_q.pop_front();
          check("enc_data", enc_data, cur.data);
          check("grant_id", grant_id, cur.id);
          check("accept_latency", cyc - cur.cyc, 1);
          check("busy_in_data", busy, 1);
        end
      end else if (enc_rdy) begin
        check("enc_data_stable", enc_data, cur.data);
      end
      prev_rdy = enc_rdy;
    end
  end

  // ---------------- ack responder ----------------
  logic resp_en = 1'b0;
  logic ack_resp = 1'b0;
  logic ack_man = 1'b0;
  int   rdly = 0;

  assign ack_async = resp_en ? ack_resp : ack_man;

  always @(negedge clk) begin
    if (resp_en && rst_n) begin
      if (enc_rdy && !ack_resp) begin
        if (rdly == 0) begin
          ack_resp = 1'b1;
          rdly = $urandom_range(0, 3);
        end else rdly--;
      end else if (!enc_rdy && ack_resp) begin
        if (rdly == 0) begin
          ack_resp = 1'b0;
          rdly = $urandom_range(0, 3);
        end else rdly--;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 3000 && (any_pending() || exp_q.size() != 0 || busy || ack_async)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, n < 3000, 1);
  endtask

  task automatic wait_rdy_rise(input string name);
    int n = 0;
    while (!enc_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_data_phase_seen"}, enc_rdy, 1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, s, bad;

    // Reset with every requester valid: outputs must all be zero.
    repeat (3) @(negedge clk);
    check("rst_enc_rdy", enc_rdy, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_req_ready", req_ready, 0);
    force_all = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin: all four requesters with two words each.
    resp_en = 1'b1;
    gnt_log.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREQ; i++) push(i, N'($urandom));
    wait_idle("rr");
    check("rr_count", gnt_log.size(), 8);
    for (int k = 0; k < gnt_log.size() && k < 8; k++) check("rr_order", gnt_log[k], k % NREQ);

    // Single transfer from requester 2 with hand-driven ack.
    resp_en = 1'b0;
    ack_man = 1'b0;
    push(2, 16'hA5C3);
    n = 0;
    while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    check("single_req_ready", req_ready, 4'b0100);
    @(negedge clk);
    check("single_enc_rdy", enc_rdy, 1);
    check("single_enc_data", enc_data, 16'hA5C3);
    check("single_grant_id", grant_id, 2);
    check("single_ready_one_cycle", req_ready, 0);
    ack_man = 1'b1;
    n = 0;
    while (enc_rdy && n < 20) begin @(negedge clk); n++; end
    check("ack_rise_latency", n, 3);
    check("spacer_busy", busy, 1);
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    check("ack_fall_latency", n, 3);

    // Pointer wrap: pointer is at 3, only requesters 1 and 3 valid.
    gnt_log.delete();
    push(3, N'($urandom));
    push(3, N'($urandom));
    push(1, N'($urandom));
    resp_en = 1'b1;
    wait_idle("wrap");
    check("wrap_count", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      check("wrap_g0", gnt_log[0], 3);
      check("wrap_g1", gnt_log[1], 1);
      check("wrap_g2", gnt_log[2], 3);
    end

    // Randomised traffic against the model.
    repeat (40) begin
      s = $urandom_range(0, NREQ - 1);
      if (tail[s] - head[s] < 15) push(s, N'($urandom));
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_idle("random");
    check("no_err_in_random", timeout_err, 0);

    // DATA timeout: ack never rises.
    resp_en = 1'b0;
    ack_man = 1'b0;
    push(0, N'($urandom));
    wait_rdy_rise("data_to");
    n = 0;
    while (enc_rdy && n < 50) begin n++; @(negedge clk); end
    check("data_timeout_cycles", n, TO);
    check("data_timeout_flag", timeout_err, 1);
    push(1, N'($urandom));
    resp_en = 1'b1;
    wait_idle("after_data_to");
    check("timeout_sticky", timeout_err, 1);
    pulse_clear();
    check("clear_err", timeout_err, 0);

    // SPACER timeout: ack held high for 40 cycles after the rise.
    resp_en = 1'b0;
    ack_man = 1'b0;
    push(1, N'($urandom));
    wait_rdy_rise("spacer_to");
    ack_man = 1'b1;
    n = 0;
    while (enc_rdy && n < 20) begin @(negedge clk); n++; end
    check("spacer_to_rise_latency", n, 3);
    push(2, N'($urandom));
    s = 1;
    bad = 0;
    while (!timeout_err && s < 60) begin
      @(negedge clk);
      s++;
      if (enc_rdy || req_ready != '0) bad++;
    end
    check("spacer_timeout_cycles", s, 11);
    repeat (40 - 3 - 10) begin
      @(negedge clk);
      if (enc_rdy || req_ready != '0) bad++;
    end
    check("spacer_hold_quiet", bad, 0);
    ack_man = 1'b0;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    check("ready_after_ack_fall", n, 3);
    resp_en = 1'b1;
    wait_idle("after_spacer_to");
    pulse_clear();
    check("clear_err_2", timeout_err, 0);

    // Reset in the middle of DATA.
    resp_en = 1'b0;
    ack_man = 1'b0;
    push(1, N'($urandom));
    wait_rdy_rise("mid_rst");
    push(0, N'($urandom));
    push(3, N'($urandom));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_enc_rdy", enc_rdy, 0);
    check("mid_rst_enc_data", enc_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    @(negedge clk);
    gnt_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    wait_idle("post_rst");
    check("post_rst_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) check("post_rst_first_grant", gnt_log[0], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
